heart_ctrl: RTL and testbench

HEART_CTRL -- requirements
Module: heart_ctrl

---
 rtl/heart_ctrl_pkg.sv | 27 ++
 rtl/heart_ctrl_lfsr10.sv | 19 +
 rtl/heart_ctrl.sv | 151 +++++++++++++++
 tb/tb_heart_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/heart_ctrl_pkg.sv
// Shared game definitions: heart FSM states, player ids and screen geometry.
package heart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    FALL   = 2'd2,
    LANDED = 2'd3
  } heart_state_t;

  typedef enum logic {
    P1 = 1'b0,
    P2 = 1'b1
  } player_t;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int SPRITE_SIZE = 16;

  localparam int         CNT_W     = 16;
  localparam logic [9:0] LFSR_SEED = 10'h2A5;

  function automatic player_t other_player(input player_t p);
    return (p == P1) ? P2 : P1;
  endfunction

endpackage

// File: rtl/heart_ctrl_lfsr10.sv
// Free-running 10-bit maximal-length LFSR (x^10 + x^7 + 1) used to randomise spawn X.
module lfsr10
  import heart_ctrl_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  output logic [9:0] q
);

  // Non-zero seed plus a maximal polynomial keeps the register out of the all-zero lockup.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      q <= LFSR_SEED;
    end else begin
      q <= {q[8:0], q[9] ^ q[6]};
    end
  end

endmodule

// File: rtl/heart_ctrl.sv
// Falling heart pickup: waits, spawns at a random X, falls to the floor, and is
// granted to whichever player touches it (round-robin on simultaneous touches).
module heart_ctrl
  import heart_ctrl_pkg::*;
#(
  parameter int SPAWN_DELAY  = 120,
  parameter int FALL_STEP    = 2,
  parameter int FLOOR_Y      = 400,
  parameter int LAND_TIMEOUT = 300,
  parameter int X_MIN        = 64
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       enable,
  input  logic       p1_hit,
  input  logic       p2_hit,
  output logic [9:0] Pos_X,
  output logic [9:0] Pos_Y,
  output logic       visible,
  output logic       grant_p1,
  output logic       grant_p2
);

  heart_state_t     state_reg, state_next;
  logic [CNT_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic [9:0]       pos_x_reg, pos_x_next;
  logic [9:0]       pos_y_reg, pos_y_next;
  logic             grant_p1_reg, grant_p1_next;
  logic             grant_p2_reg, grant_p2_next;
  player_t          rr_reg, rr_next;
  logic             frame_prev_reg;

  logic [9:0]  lfsr_q;
  logic        lfsr_unused;
  logic        frame_tick;
  logic        pickup;
  logic [10:0] fall_sum;
  logic [9:0]  spawn_x;
  player_t     winner;

  lfsr10 u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .q     (lfsr_q)
  );

  // Only the low nine bits feed the spawn column; the top bit just keeps the sequence going.
  assign lfsr_unused = lfsr_q[9];
  assign spawn_x     = 10'(X_MIN) + {1'b0, lfsr_q[8:0]};

  assign frame_tick = frame_clk & ~frame_prev_reg;
  assign fall_sum   = {1'b0, pos_y_reg} + 11'(FALL_STEP);
  assign pickup     = ((state_reg == FALL) || (state_reg == LANDED)) && (p1_hit || p2_hit);

  always_comb begin
    state_next     = state_reg;
    frame_cnt_next = frame_cnt_reg;
    pos_x_next     = pos_x_reg;
    pos_y_next     = pos_y_reg;
    grant_p1_next  = 1'b0;
    grant_p2_next  = 1'b0;
    rr_next        = rr_reg;
    winner         = P1;

    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next     = WAIT;
          frame_cnt_next = '0;
        end
        WAIT: begin
          if (frame_tick) begin
            if (frame_cnt_reg == CNT_W'(SPAWN_DELAY - 1)) begin
              state_next     = FALL;
              pos_x_next     = spawn_x;
              pos_y_next     = '0;
              frame_cnt_next = '0;
            end else begin
              frame_cnt_next = frame_cnt_reg + CNT_W'(1);
            end
          end
        end
        FALL, LANDED: begin
          // A touch beats any motion or timeout due on the same cycle.
          if (pickup) begin
            if (p1_hit && !p2_hit) begin
              winner = P1;
            end else if (p2_hit && !p1_hit) begin
              winner = P2;
            end else begin
              winner = rr_reg;
            end
            grant_p1_next  = (winner == P1);
            grant_p2_next  = (winner == P2);
            rr_next        = other_player(winner);
            state_next     = WAIT;
            frame_cnt_next = '0;
          end else if (frame_tick) begin
            if (state_reg == FALL) begin
              if (fall_sum >= 11'(FLOOR_Y)) begin
                pos_y_next     = 10'(FLOOR_Y);
                state_next     = LANDED;
                frame_cnt_next = '0;
              end else begin
                pos_y_next = fall_sum[9:0];
              end
            end else if (frame_cnt_reg == CNT_W'(LAND_TIMEOUT - 1)) begin
              state_next     = WAIT;
              frame_cnt_next = '0;
            end else begin
              frame_cnt_next = frame_cnt_reg + CNT_W'(1);
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg      <= IDLE;
      frame_cnt_reg  <= '0;
      pos_x_reg      <= '0;
      pos_y_reg      <= '0;
      grant_p1_reg   <= 1'b0;
      grant_p2_reg   <= 1'b0;
      rr_reg         <= P1;
      frame_prev_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      frame_cnt_reg  <= frame_cnt_next;
      pos_x_reg      <= pos_x_next;
      pos_y_reg      <= pos_y_next;
      grant_p1_reg   <= grant_p1_next;
      grant_p2_reg   <= grant_p2_next;
      rr_reg         <= rr_next;
      frame_prev_reg <= frame_clk;
    end
  end

  assign Pos_X    = pos_x_reg;
  assign Pos_Y    = pos_y_reg;
  assign visible  = (state_reg == FALL) || (state_reg == LANDED);
  assign grant_p1 = grant_p1_reg;
  assign grant_p2 = grant_p2_reg;

endmodule

// File: tb/tb_heart_ctrl.sv
// Self-checking bench for heart_ctrl: per-cycle reference model plus directed literal checks.
module tb_heart_ctrl;

  localparam int SD = 4;
  localparam int LT = 3;
  localparam int FS = 2;
  localparam int FY = 8;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_clk = 1'b0;
  logic       enable = 1'b0;
  logic       p1_hit = 1'b0;
  logic       p2_hit = 1'b0;
  logic [9:0] Pos_X, Pos_Y;
  logic       visible, grant_p1, grant_p2;

  int compared = 0;
  int mismatched = 0;

  always #5 Clk = ~Clk;

  heart_ctrl #(
    .SPAWN_DELAY  (SD),
    .FALL_STEP    (FS),
    .FLOOR_Y      (FY),
    .LAND_TIMEOUT (LT),
    .X_MIN        (64)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .enable    (enable),
    .p1_hit    (p1_hit),
    .p2_hit    (p2_hit),
    .Pos_X     (Pos_X),
    .Pos_Y     (Pos_Y),
    .visible   (visible),
    .grant_p1  (grant_p1),
    .grant_p2  (grant_p2)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: a heart is either absent, counting down to spawn, falling, or resting.
  localparam int M_IDLE = 0, M_WAIT = 1, M_FALL = 2, M_LAND = 3;
  int m_mode, m_left, m_y, m_next_tie, m_win;
  bit m_g1, m_g2, m_prev, m_tick;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_mode = M_IDLE; m_left = 0; m_y = 0; m_next_tie = 1;
      m_g1 = 0; m_g2 = 0; m_prev = 0;
    end else begin
      m_tick = frame_clk && !m_prev;
      m_prev = frame_clk;
      m_g1 = 0; m_g2 = 0;
      if (!enable) begin
        m_mode = M_IDLE;
      end else if ((m_mode == M_FALL || m_mode == M_LAND) && (p1_hit || p2_hit)) begin
        m_win = (p1_hit && p2_hit) ? m_next_tie : (p1_hit ? 1 : 2);
        if (m_win == 1) m_g1 = 1; else m_g2 = 1;
        m_next_tie = 3 - m_win;
        m_mode = M_WAIT; m_left = SD;
      end else if (m_mode == M_IDLE) begin
        m_mode = M_WAIT; m_left = SD;
      end else if (m_tick) begin
        case (m_mode)
          M_WAIT: begin
            m_left--;
            if (m_left == 0) begin m_mode = M_FALL; m_y = 0; end
          end
          M_FALL: begin
            m_y = (m_y + FS >= FY) ? FY : m_y + FS;
            if (m_y == FY) begin m_mode = M_LAND; m_left = LT; end
          end
          M_LAND: begin
            m_left--;
            if (m_left == 0) begin m_mode = M_WAIT; m_left = SD; end
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge Clk) begin
    check("visible", visible, (m_mode == M_FALL || m_mode == M_LAND));
    check("pos_y", Pos_Y, m_y);
    check("grant_p1", grant_p1, m_g1);
    check("grant_p2", grant_p2, m_g2);
    check("grant_exclusive", grant_p1 & grant_p2, 0);
    if (visible) check("pos_x_range", (Pos_X >= 10'd64 && Pos_X <= 10'd575), 1);
  end

  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  task automatic tick();
    frame_clk = 1'b1; step();
    frame_clk = 1'b0; step();
    step();
  endtask

  task automatic hit(input logic a, input logic b);
    p1_hit = a; p2_hit = b; step();
    p1_hit = 1'b0; p2_hit = 1'b0;
  endtask

  int fall_steps [4] = '{2, 4, 6, 8};

  initial begin
    repeat (3) step();
    check("rst_visible", visible, 0);
    check("rst_pos_x", Pos_X, 0);
    check("rst_pos_y", Pos_Y, 0);
    check("rst_grants", {grant_p1, grant_p2}, 0);

    // Run briefly, then reset mid-run before the real spawn sequence.
    Reset = 1'b1; enable = 1'b1; step();
    tick(); tick();
    Reset = 1'b0; step();
    Reset = 1'b1; step();
    repeat (4) tick();
    check("spawn_visible", visible, 1);
    check("spawn_pos_y", Pos_Y, 0);
    check("spawn_pos_x_range", (Pos_X >= 10'd64 && Pos_X <= 10'd575), 1);

    foreach (fall_steps[i]) begin
      tick();
      check("fall_pos_y", Pos_Y, fall_steps[i]);
    end
    check("landed_visible", visible, 1);
    repeat (3) tick();
    check("timeout_visible", visible, 0);
    check("timeout_pos_y", Pos_Y, 8);

    // Single-player pickup while resting on the floor.
    repeat (8) tick();
    hit(1'b0, 1'b1);
    check("p2_grant", grant_p2, 1);
    check("p2_grant_other", grant_p1, 0);
    check("p2_grant_visible", visible, 0);
    step();
    check("p2_grant_pulse_end", grant_p2, 0);

    // Simultaneous touches from reset alternate P1 then P2.
    Reset = 1'b0; step();
    Reset = 1'b1; step();
    repeat (4) tick();
    hit(1'b1, 1'b1);
    check("tie1_p1", grant_p1, 1);
    check("tie1_p2", grant_p2, 0);
    step();
    repeat (4) tick();
    hit(1'b1, 1'b1);
    check("tie2_p1", grant_p1, 0);
    check("tie2_p2", grant_p2, 1);

    // Pickup landing on the same cycle as a frame tick freezes the position.
    step();
    repeat (4) tick();
    tick(); tick();
    check("pre_pick_pos_y", Pos_Y, 4);
    frame_clk = 1'b1; p1_hit = 1'b1; step();
    frame_clk = 1'b0; p1_hit = 1'b0;
    check("tick_pick_grant", grant_p1, 1);
    check("tick_pick_pos_y", Pos_Y, 4);
    step(); step();
    check("tick_pick_after_visible", visible, 0);

    // Disable mid-fall, then touches must be ignored.
    repeat (4) tick();
    tick();
    enable = 1'b0; step();
    check("disable_visible", visible, 0);
    check("disable_pos_y", Pos_Y, 2);
    hit(1'b1, 1'b1);
    check("disable_no_grant", {grant_p1, grant_p2}, 0);
    enable = 1'b1; step();
    hit(1'b1, 1'b0);
    check("wait_no_grant", grant_p1, 0);

    // Reset mid-fall drops visibility immediately.
    repeat (4) tick();
    check("prerst_visible", visible, 1);
    #2; Reset = 1'b0; #1;
    check("rst_fall_visible", visible, 0);
    check("rst_fall_pos_y", Pos_Y, 0);
    step();
    Reset = 1'b1; step();

    // Reset during a grant pulse kills it with nothing left over.
    repeat (4) tick();
    p1_hit = 1'b1;
    @(posedge Clk); #1;
    p1_hit = 1'b0;
    check("pre_rst_grant", grant_p1, 1);
    Reset = 1'b0; #1;
    check("rst_grant_cleared", grant_p1, 0);
    step();
    Reset = 1'b1; step(); step();
    check("post_rst_grant", {grant_p1, grant_p2}, 0);
    check("post_rst_pos_x", Pos_X, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
